sub_arbiter: RTL and testbench

- Shares one 16-bit unsigned subtract unit (difference = A − B modulo 2^WIDTH) among NREQ requesters.
- Uses round-robin arbitration with valid/ready handshakes.
- Registers the result with the winning requester's ID and a borrow flag.
- Sits between the requesting datapath blocks and the shared subtractor, and is the only path to it.

---
 rtl/sub_arbiter.sv | 111 +++++++++++
 tb/tb_sub_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// Round-robin arbiter in front of one shared WIDTH-bit subtractor. The result is held
// in a single registered slot with valid/ready on both the request and result sides.
`timescale 1ns/1ps
module sub_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic                  res_borrow,
    output logic [IDW-1:0]        res_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             borrow_q, borrow_d;
    logic [IDW-1:0]   id_q, id_d;

    logic             slot_free;
    logic             found;
    logic             accept;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   gnt_idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   diff;

    assign slot_free = (state_q == EMPTY) || res_ready;

    // First valid requester at or after ptr, wrapping; invalid requesters earn no credit.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand = IDW'((32'(ptr_q) + off) % NREQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept = slot_free && found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a = req_a[32'(gnt_idx)*WIDTH +: WIDTH];
    assign op_b = req_b[32'(gnt_idx)*WIDTH +: WIDTH];
    // Extra MSB captures the borrow out of the unsigned subtraction.
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        data_d   = data_q;
        borrow_d = borrow_q;
        id_d     = id_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (res_ready) state_d = accept ? FULL : EMPTY;
        endcase
        if (accept) begin
            data_d   = diff[WIDTH-1:0];
            borrow_d = diff[WIDTH];
            id_d     = gnt_idx;
            ptr_d    = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            ptr_q    <= '0;
            data_q   <= '0;
            borrow_q <= 1'b0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            borrow_q <= borrow_d;
            id_q     <= id_d;
        end
    end

    assign res_valid  = (state_q == FULL);
    assign res_data   = data_q;
    assign res_borrow = borrow_q;
    assign res_id     = id_q;

endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: table of grant sequences and arithmetic corners, with expected
// results queued at stimulus time and popped when the registered result appears.
`timescale 1ns/1ps
module tb_sub_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic                  res_borrow;
    logic [IDW-1:0]        res_id;

    always #5 clk = ~clk;

    sub_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_borrow (res_borrow),
        .res_id     (res_id)
    );

    typedef struct { logic [3:0] valid; logic rdy; int gnt; } seq_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] d; logic bw; } arith_t;
    typedef struct { logic [15:0] d; logic bw; logic [1:0] id; } res_t;

    seq_t        seq_tbl [22];
    arith_t      ar_tbl  [6];
    res_t        exp_q [$];
    res_t        held;
    logic        exp_valid;
    logic [15:0] a_arr [4];
    logic [15:0] b_arr [4];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 16'($urandom);
            b_arr[i] = 16'($urandom);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = a_arr[i];
            req_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
    endtask

    // Called at posedge+1; g is the requester expected to be granted this cycle, or -1.
    task automatic step(input logic [3:0] v, input logic rdy, input int g);
        logic [3:0] exp_rr;
        res_t       e;
        drive_ops();
        req_valid = v;
        res_ready = rdy;
        exp_rr    = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        #3;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        if (g >= 0) begin
            e.d  = a_arr[g] - b_arr[g];
            e.bw = (a_arr[g] < b_arr[g]);
            e.id = 2'(g);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            exp_valid = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                held = exp_q.pop_front();
            end
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        chk("res_valid", 32'(res_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("res_data", 32'(res_data), 32'(held.d));
            chk("res_borrow", 32'(res_borrow), 32'(held.bw));
            chk("res_id", 32'(res_id), 32'(held.id));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_tbl = '{
            '{4'b1111, 1'b1,  0}, '{4'b1111, 1'b1,  1}, '{4'b1111, 1'b1,  2},
            '{4'b1111, 1'b1,  3}, '{4'b1111, 1'b1,  0}, '{4'b1111, 1'b1,  1},
            '{4'b1010, 1'b1,  3}, '{4'b1010, 1'b1,  1}, '{4'b1010, 1'b1,  3},
            '{4'b0011, 1'b0, -1}, '{4'b0011, 1'b0, -1}, '{4'b0011, 1'b0, -1},
            '{4'b0011, 1'b0, -1}, '{4'b0011, 1'b0, -1},
            '{4'b0011, 1'b1,  0}, '{4'b0011, 1'b1,  1},
            '{4'b0000, 1'b1, -1}, '{4'b0000, 1'b1, -1}, '{4'b0000, 1'b0, -1},
            '{4'b1001, 1'b0,  3}, '{4'b1001, 1'b0, -1}, '{4'b1111, 1'b1,  0}
        };
        ar_tbl = '{
            '{16'h1234, 16'h0234, 16'h1000, 1'b0},
            '{16'h0000, 16'h0001, 16'hFFFF, 1'b1},
            '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0},
            '{16'h0005, 16'h0003, 16'h0002, 1'b0},
            '{16'h8000, 16'h8001, 16'hFFFF, 1'b1},
            '{16'h0001, 16'hFFFF, 16'h0002, 1'b1}
        };
        exp_valid = 1'b0;
        held      = '{16'h0, 1'b0, 2'd0};

        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        rand_ops();
        drive_ops();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_valid", 32'(res_valid), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_data", 32'(res_data), 32'd0);
            chk("rst_id", 32'(res_id), 32'd0);
            chk("rst_borrow", 32'(res_borrow), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            rand_ops();
            step(seq_tbl[i].valid, seq_tbl[i].rdy, seq_tbl[i].gnt);
        end

        for (int i = 0; i < 6; i++) begin
            rand_ops();
            a_arr[2] = ar_tbl[i].a;
            b_arr[2] = ar_tbl[i].b;
            step(4'b0100, 1'b1, 2);
            chk("arith_data", 32'(res_data), 32'(ar_tbl[i].d));
            chk("arith_borrow", 32'(res_borrow), 32'(ar_tbl[i].bw));
        end

        rand_ops();
        step(4'b0001, 1'b1, 0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        chk("midrst_id", 32'(res_id), 32'd0);
        chk("midrst_borrow", 32'(res_borrow), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        exp_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        rand_ops();
        step(4'b1111, 1'b1, 0);
        rand_ops();
        step(4'b1111, 1'b1, 1);
        step(4'b0000, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
